// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache line fill engine.
// Holds the fill FSM state encoding and the line/word geometry that the
// fill engine and its helpers agree on.
package icache_pkg;

  localparam int WORD_W         = 32;   // instruction memory bus width
  localparam int LINE_W         = 128;  // cache line width, four bus words
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_OFF_W     = 4;    // byte offset bits inside a line
  localparam int WORD_OFF_W     = 2;    // byte offset bits inside a word
  localparam int BEAT_W         = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_BURST,
    FILL_DONE,
    FILL_ERR
  } fill_state_e;

endpackage

// File: rtl/fill_timeout_ctr.sv
// Per-beat timeout counter for the line fill engine.
// Loads TIMEOUT-1 when a beat starts (or is acknowledged) and counts down on
// every enabled cycle; expired is high while enabled with the count at zero,
// i.e. in the last cycle a beat may still be acknowledged.
// Ports:
//   clk, rst  - clock and synchronous active-low reset
//   load      - restart the count for a new beat
//   en        - count this cycle (engine is waiting on the bus)
//   expired   - wait budget for the current beat is used up
module fill_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: clocked state is written with non-blocking assignments so every
  // flop samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/icache_line_fill.sv
// Memory-side line fill engine below the instruction cache.
// A line request is split into four sequential single-word reads on the
// instruction memory bus; the words are assembled into one line that is
// returned with a one-cycle mem_ready pulse. A bus error or a beat that is
// never acknowledged ends the fill with a one-cycle fill_err pulse instead.
// Ports:
//   clk, rst              - clock, synchronous active-low reset
//   mem_r, mem_addr       - line request from the cache (addr[3:0] ignored)
//   mem_data, mem_ready   - assembled line and its valid pulse
//   fill_err              - fill failed (bus error or timeout)
//   bus_req, bus_addr     - word read request to instruction memory
//   bus_ack, bus_rdata    - request accepted, read data valid
//   bus_err               - the acknowledged beat failed
module icache_line_fill #(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              fill_err,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [WORD_W-1:0] bus_rdata,
  input  logic              bus_err
);

  import icache_pkg::*;

  fill_state_e state_q, state_d;

  logic [BEAT_W-1:0]        beat_q;
  logic                     abort_q;
  logic                     bus_req_q;
  logic [ADDR_W-1:0]        bus_addr_q;
  logic                     mem_ready_q;
  logic                     fill_err_q;
  logic [LINE_W-1:0]        mem_data_q;
  logic [LINE_W-WORD_W-1:0] shadow_q;   // words 0..2 of the line in flight

  logic ack_ok;
  logic last_beat;
  logic aborting;
  logic tmo_load;
  logic tmo_en;
  logic tmo_expired;

  // The line offset of the request address carries no information.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, mem_addr[LINE_OFF_W-1:0]};

  assign ack_ok    = bus_ack && !bus_err;
  assign last_beat = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));
  // The cache may drop mem_r at any point of the burst; remember it so the
  // burst ends quietly once the outstanding beat has been acknowledged.
  assign aborting  = abort_q || !mem_r;

  assign tmo_load = ((state_q == FILL_IDLE) && mem_r) ||
                    ((state_q == FILL_BURST) && bus_ack);
  assign tmo_en   = (state_q == FILL_BURST);

  fill_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // NOTE: state_d gets a default before the case so that no path through
  // this block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL_IDLE: begin
        if (mem_r) state_d = FILL_BURST;
      end
      FILL_BURST: begin
        if (bus_ack) begin
          if (aborting)       state_d = FILL_IDLE;
          else if (bus_err)   state_d = FILL_ERR;
          else if (last_beat) state_d = FILL_DONE;
        end else if (tmo_expired) begin
          state_d = aborting ? FILL_IDLE : FILL_ERR;
        end
      end
      FILL_DONE: state_d = FILL_IDLE;
      FILL_ERR:  state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL_IDLE;
      beat_q      <= '0;
      abort_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_addr_q  <= '0;
      mem_ready_q <= 1'b0;
      fill_err_q  <= 1'b0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      // Outputs follow the next state so they are clean flop outputs.
      bus_req_q   <= (state_d == FILL_BURST);
      mem_ready_q <= (state_d == FILL_DONE);
      fill_err_q  <= (state_d == FILL_ERR);
      abort_q     <= (state_q == FILL_BURST) && (state_d == FILL_BURST) &&
                     aborting;

      if ((state_q == FILL_IDLE) && mem_r) begin
        bus_addr_q <= {mem_addr[ADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)};
        beat_q     <= '0;
      end else if ((state_q == FILL_BURST) && ack_ok && !last_beat) begin
        beat_q <= beat_q + 1'b1;
        // Only the word-select bits move, so the burst never carries into
        // the tag bits above the line.
        bus_addr_q[LINE_OFF_W-1:WORD_OFF_W] <= beat_q + 1'b1;
      end

      // The visible line only changes when all four beats succeeded.
      if (state_d == FILL_DONE) begin
        mem_data_q <= {bus_rdata, shadow_q};
      end
    end
  end

  // NOTE: the shadow is pure datapath storage that is always written before
  // it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if ((state_q == FILL_BURST) && ack_ok && !last_beat) begin
      shadow_q[beat_q*WORD_W +: WORD_W] <= bus_rdata;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_addr  = bus_addr_q;
  assign mem_ready = mem_ready_q;
  assign fill_err  = fill_err_q;
  assign mem_data  = mem_data_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill.
// A memory responder answers each word request after a per-beat delay and can
// inject a bus error or withhold the ack of one beat. Fill outcomes, latency,
// issued addresses and line contents are compared against expectations from a
// vector table, hand-written corner sequences and a beat-walk model.
module tb_icache_line_fill;

  localparam int TIMEOUT = 8;
  localparam int NONE    = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_r;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data;
  logic         mem_ready;
  logic         fill_err;
  logic         bus_req;
  logic [31:0]  bus_addr;
  logic         bus_ack;
  logic [31:0]  bus_rdata;
  logic         bus_err;

  always #5 clk = ~clk;

  icache_line_fill #(
    .ADDR_W  (32),
    .WORD_W  (32),
    .LINE_W  (128),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r     (mem_r),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .fill_err  (fill_err),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err)
  );

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;       // word i at [32i+31:32i]
    logic [15:0]  dly;        // ack delay of beat i at [4i+3:4i]
    logic [2:0]   err_beat;   // NONE = no error
    logic [2:0]   hang_beat;  // NONE = every beat acked
    logic         exp_ready;
    logic         exp_err;
    logic [7:0]   exp_lat;
    logic [127:0] exp_line;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]  cfg_data [4];
  int           cfg_dly  [4];
  int           cfg_err_beat  = NONE;
  int           cfg_hang_beat = NONE;
  bit           cfg_force_ack = 1'b0;
  logic [31:0]  addr_log [$];
  int           addr_unstable = 0;
  logic [127:0] model_line = '0;

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory responder: drives the bus inputs on the falling edge.
  initial begin
    int  wait_cnt;
    int  beat;
    bit  waiting;
    logic [31:0] prev_addr;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    wait_cnt = 0; waiting = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      if (cfg_force_ack) begin
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
      end else if (bus_req) begin
        if (waiting && (bus_addr != prev_addr)) addr_unstable++;
        beat = int'(bus_addr[3:2]);
        if ((beat != cfg_hang_beat) && (wait_cnt == cfg_dly[beat])) begin
          bus_ack   = 1'b1;
          bus_rdata = cfg_data[beat];
          bus_err   = (beat == cfg_err_beat);
          addr_log.push_back(bus_addr);
          wait_cnt  = 0;
          waiting   = 1'b0;
        end else begin
          wait_cnt++;
          waiting = 1'b1;
        end
      end else begin
        wait_cnt = 0;
        waiting  = 1'b0;
      end
      prev_addr = bus_addr;
    end
  end

  function automatic vec_t mk(input logic [31:0] a, input logic [127:0] d,
                              input logic [15:0] dl, input int eb, input int hb,
                              input bit r, input int lat,
                              input logic [127:0] line);
    vec_t v;
    v.addr = a; v.data = d; v.dly = dl;
    v.err_beat = 3'(eb); v.hang_beat = 3'(hb);
    v.exp_ready = r; v.exp_err = !r; v.exp_lat = 8'(lat); v.exp_line = line;
    return v;
  endfunction

  // Cache side of one fill: raise mem_r, wait for a pulse, count cycles.
  task automatic run_fill(input logic [31:0] addr, input bit hold,
                          output int lat, output bit rdy, output bit err,
                          output logic [127:0] line);
    addr_log.delete();
    addr_unstable = 0;
    @(posedge clk); #1;
    mem_r = 1'b1; mem_addr = addr;
    lat = 0; rdy = 1'b0; err = 1'b0; line = 'x;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (mem_ready || fill_err) begin
        rdy = mem_ready; err = fill_err; line = mem_data;
        if (!hold) mem_r = 1'b0;
        break;
      end
    end
    if (!(rdy || err)) mem_r = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int lat, n;
    bit rdy, err;
    logic [127:0] line;
    logic [31:0] base;
    for (int i = 0; i < 4; i++) begin
      cfg_data[i] = v.data[32*i +: 32];
      cfg_dly[i]  = int'(v.dly[4*i +: 4]);
    end
    cfg_err_beat  = int'(v.err_beat);
    cfg_hang_beat = int'(v.hang_beat);
    run_fill(v.addr, 1'b0, lat, rdy, err, line);
    check({tag, "_ready"}, 128'(rdy), 128'(v.exp_ready));
    check({tag, "_err"},   128'(err), 128'(v.exp_err));
    check({tag, "_lat"},   128'(lat), 128'(v.exp_lat));
    check({tag, "_line"},  line, v.exp_line);
    if (v.exp_ready)          n = 4;
    else if (v.err_beat < 4)  n = int'(v.err_beat) + 1;
    else                      n = int'(v.hang_beat);
    base = {v.addr[31:4], 4'h0};
    check({tag, "_nbeats"}, 128'(addr_log.size()), 128'(n));
    for (int i = 0; i < n; i++)
      check({tag, "_addr"}, 128'((i < addr_log.size()) ? addr_log[i] : 32'hxxxxxxxx),
            128'(base + 32'(4*i)));
    check({tag, "_addr_stable"}, 128'(addr_unstable), 128'(0));
    model_line = v.exp_line;
    @(negedge clk);
    check({tag, "_quiet"}, 128'({mem_ready, fill_err, bus_req}), 128'(0));
    check({tag, "_hold"}, mem_data, model_line);
    cfg_err_beat = NONE; cfg_hang_beat = NONE;
  endtask

  // Reference: walk the beats in order, each costs delay+1 cycles, a withheld
  // ack costs TIMEOUT cycles; an error or hang ends the fill.
  function automatic vec_t make_rand();
    vec_t v;
    int   r, lat;
    bit   ok;
    v.addr = $urandom;
    v.data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) v.dly[4*i +: 4] = 4'($urandom_range(0, 3));
    r = $urandom_range(0, 9);
    v.err_beat  = 3'(NONE);
    v.hang_beat = 3'(NONE);
    if (r < 2)      v.err_beat  = 3'($urandom_range(0, 3));
    else if (r < 3) v.hang_beat = 3'($urandom_range(0, 3));
    lat = 2; ok = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b == int'(v.hang_beat)) begin lat += TIMEOUT; ok = 1'b0; break; end
      lat += int'(v.dly[4*b +: 4]) + 1;
      if (b == int'(v.err_beat)) begin ok = 1'b0; break; end
    end
    v.exp_ready = ok;
    v.exp_err   = !ok;
    v.exp_lat   = 8'(lat);
    v.exp_line  = ok ? v.data : model_line;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int   lat, cnt, gap;
    bit   rdy, err, found;
    logic [127:0] line;

    vecs[0] = mk(32'hFFFFFFFC, 128'hF0000000_00000000_00000000_00000000, 16'h0000,
                 NONE, NONE, 1, 6, 128'hF0000000_00000000_00000000_00000000);
    vecs[1] = mk(32'h11111FF0, 128'h00000000_00000000_00000000_FFFFFFFF, 16'h3333,
                 NONE, NONE, 1, 18, 128'h00000000_00000000_00000000_FFFFFFFF);
    vecs[2] = mk(32'h00001230, 128'h33333333_22222222_11111111_00000000, 16'h0000,
                 2, NONE, 0, 5, 128'h00000000_00000000_00000000_FFFFFFFF);
    vecs[3] = mk(32'h40000008, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 16'h0000,
                 NONE, 1, 0, 11, 128'h00000000_00000000_00000000_FFFFFFFF);
    vecs[4] = mk(32'h80000004, 128'h44444444_33333333_22222222_11111111, 16'h0201,
                 NONE, NONE, 1, 9, 128'h44444444_33333333_22222222_11111111);
    vecs[5] = mk(32'h20000000, 128'h55555555_55555555_55555555_55555555, 16'h0007,
                 0, NONE, 0, 10, 128'h44444444_33333333_22222222_11111111);
    vecs[6] = mk(32'h12345670, 128'h89ABCDEF_01234567_FEDCBA98_76543210, 16'h0070,
                 NONE, NONE, 1, 13, 128'h89ABCDEF_01234567_FEDCBA98_76543210);

    rst = 1'b0; mem_r = 1'b0; mem_addr = '0;
    for (int i = 0; i < 4; i++) begin cfg_data[i] = '0; cfg_dly[i] = 0; end
    repeat (3) @(negedge clk);
    check("reset_ctrl", 128'({bus_req, mem_ready, fill_err}), 128'(0));
    check("reset_addr", 128'(bus_addr), 128'(0));
    check("reset_data", mem_data, 128'(0));
    rst = 1'b1;

    for (int i = 0; i < 7; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort: mem_r drops while beat 1 waits for its ack.
    cfg_data[0] = 32'h01010101; cfg_data[1] = 32'h02020202;
    cfg_data[2] = 32'h03030303; cfg_data[3] = 32'h04040404;
    cfg_dly[0] = 0; cfg_dly[1] = 4; cfg_dly[2] = 0; cfg_dly[3] = 0;
    addr_log.delete();
    @(posedge clk); #1;
    mem_r = 1'b1; mem_addr = 32'h0000A5A0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus_req && (bus_addr == 32'h0000A5A4)) found = 1'b1;
    end
    check("abort_reach_beat1", 128'(found), 128'(1));
    mem_r = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_ready || fill_err) cnt++;
    end
    check("abort_no_pulse", 128'(cnt), 128'(0));
    check("abort_nbeats", 128'(addr_log.size()), 128'(2));
    check("abort_beat1_done", 128'((addr_log.size() > 1) ? addr_log[1] : 32'hxxxxxxxx),
          128'(32'h0000A5A4));
    check("abort_idle", 128'(bus_req), 128'(0));
    check("abort_line", mem_data, model_line);

    // Reset in the middle of a burst, then a stray ack.
    cfg_hang_beat = 0;
    @(posedge clk); #1;
    mem_r = 1'b1; mem_addr = 32'h00007770;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus_req) found = 1'b1;
    end
    check("rst_burst_started", 128'(found), 128'(1));
    rst = 1'b0; mem_r = 1'b0;
    @(negedge clk);
    check("rst_mid_ctrl", 128'({bus_req, mem_ready, fill_err}), 128'(0));
    check("rst_mid_addr", 128'(bus_addr), 128'(0));
    check("rst_mid_data", mem_data, 128'(0));
    model_line = '0;
    rst = 1'b1; cfg_force_ack = 1'b1; cfg_hang_beat = NONE;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus_req || mem_ready || fill_err) cnt++;
    end
    cfg_force_ack = 1'b0;
    check("rst_stray_ack", 128'(cnt), 128'(0));
    check("rst_stray_data", mem_data, 128'(0));

    // Held request: mem_r stays high across DONE, a second fill follows.
    cfg_dly[1] = 0;
    cfg_data[0] = 32'hA0000000; cfg_data[1] = 32'hA1111111;
    cfg_data[2] = 32'hA2222222; cfg_data[3] = 32'hA3333333;
    run_fill(32'h00C0FFE4, 1'b1, lat, rdy, err, line);
    check("held_first_lat", 128'(lat), 128'(6));
    check("held_first_ready", 128'({rdy, err}), 128'(2'b10));
    check("held_first_line", line, 128'hA3333333_A2222222_A1111111_A0000000);
    cfg_data[0] = 32'hB0000000; cfg_data[1] = 32'hB1111111;
    cfg_data[2] = 32'hB2222222; cfg_data[3] = 32'hB3333333;
    gap = 0;
    for (int c = 1; c <= 20 && gap == 0; c++) begin
      @(negedge clk);
      if (c == 1) check("held_idle_cycle", 128'({bus_req, mem_ready}), 128'(0));
      if (mem_ready) gap = c;
    end
    mem_r = 1'b0;
    check("held_second_gap", 128'(gap), 128'(6));
    check("held_second_line", mem_data, 128'hB3333333_B2222222_B1111111_B0000000);
    check("held_nbeats", 128'(addr_log.size()), 128'(8));
    model_line = 128'hB3333333_B2222222_B1111111_B0000000;
    @(negedge clk);
    check("held_quiet", 128'({mem_ready, fill_err, bus_req}), 128'(0));

    for (int i = 0; i < 40; i++) apply_vec(make_rand(), $sformatf("rand%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
